tree_adder_scheduler: RTL
=========================

TREE_ADDER_SCHEDULER -- requirements
Module: tree_adder_scheduler

Interface
REQ-001 Parameter FAIR, default 1: 1 = round-robin arbitration between requesters; 0 = fixed priority, requester 0 wins.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  input  4 each  narrow operands of requester 0 / 1.
REQ-006 c0, d0 / c1, d1  input  8 each  wide operands of requester 0 / 1.
REQ-007 gnt0, gnt1  output  1 each  grant; operands of that requester are captured at the end of the cycle in which it is high.
REQ-008 busy  output  1  high from the cycle after a grant through the done cycle inclusive.
REQ-009 done  output  1  one-cycle pulse; sum outputs are valid for the granted operation.
REQ-010 done_id  output  1  requester index of the completed operation, valid with done.
REQ-011 sum1 / sum2 / sum3  output  5 / 9 / 10  a+b, c+d, and sum1+sum2 of the granted operand set.

Function
REQ-012 FSM states SHALL be IDLE, S1, S2, S3, DONE.
REQ-013 Transitions SHALL be IDLE->S1 on a grant, S1->S2, S2->S3, S3->DONE and DONE->IDLE unconditionally; IDLE SHALL hold while there is no request.
REQ-014 gnt0/gnt1 SHALL be combinational and asserted only in IDLE; at most one SHALL be high in any cycle.
REQ-015 Arbitration SHALL apply only when both requests are high: FAIR=1 grants the requester not served last (last_id register); FAIR=0 grants requester 0.
REQ-016 The grant edge SHALL capture a, b, c, d and the requester id into internal registers; requests arriving outside IDLE SHALL be ignored (gnt=0), and requesters SHALL hold req and operands until granted.
REQ-017 One shared 10-bit adder with zero-extended inputs SHALL perform all additions, muxed by state: S1 a+b -> sum1, S2 c+d -> sum2, S3 sum1+sum2 -> sum3.
REQ-018 Each sum register SHALL load only on the edge leaving its state; no truncation, since the maximum sum3 of 540 fits in 10 bits.
REQ-019 done SHALL be high exactly during DONE, i.e. the 4th cycle after the grant cycle; done_id SHALL equal the captured id.
REQ-020 sum1/sum2/sum3/done_id SHALL hold their values until overwritten by the next operation.
REQ-021 Minimum spacing between grants SHALL be 5 cycles; a request pending during DONE SHALL be granted in the following IDLE cycle.
REQ-022 last_id SHALL update on every grant.

Reset
REQ-023 While reset is high at a clock edge: state=IDLE; busy, done, done_id, sum1, sum2, sum3 = 0; last_id=1, so requester 0 wins the first tie.
REQ-024 Reset mid-operation SHALL abandon the operation with no done pulse.
REQ-025 gnt0/gnt1 SHALL be forced low during any cycle in which reset is high.

Structure
REQ-026 Package tree_adder_pkg SHALL hold the state encoding typedef and the width constants (NARROW_W=4, WIDE_W=8, SUM3_W=10).
REQ-027 Sub-module shared_adder10 SHALL be the purely combinational 10-bit adder; the FSM, arbiter and registers SHALL live in tree_adder_scheduler.

Verification
REQ-028 req0 with a=0, b=3, c=1, d=255 -> gnt0 same cycle; done 4 cycles later with sum1=3, sum2=256, sum3=259, done_id=0.
REQ-029 req1 with a=10, b=13, c=9, d=10 -> sum1=23, sum2=19, sum3=42, done_id=1; a second run with a=15, b=15, c=109, d=37 -> 30/146/176.
REQ-030 Max operands a=b=15, c=d=255 -> sum1=30, sum2=510, sum3=540, no overflow.
REQ-031 req0 and req1 held high continuously, FAIR=1 -> grants alternate 0,1,0,1 with 5-cycle spacing; FAIR=0 -> only gnt0 is ever issued.
REQ-032 reset asserted in S2 -> next cycle state IDLE, all outputs 0, no done; a req1 pulse during busy -> no gnt1.

Source files
------------

// File: rtl/tree_adder_pkg.sv
// Shared types and widths for the tree adder scheduler.
// State encoding and operand/sum widths live here.
package tree_adder_pkg;

  localparam int NARROW_W = 4;
  localparam int WIDE_W   = 8;
  localparam int SUM3_W   = 10;
  localparam int SUM1_W   = NARROW_W + 1;
  localparam int SUM2_W   = WIDE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    S3,
    DONE
  } state_e;

endpackage

// File: rtl/shared_adder10.sv
// Single combinational adder reused by every phase of the scheduler.
// Inputs arrive already zero-extended to the full sum width.
module shared_adder10
  import tree_adder_pkg::*;
(
  input  logic [SUM3_W-1:0] a_i,
  input  logic [SUM3_W-1:0] b_i,
  output logic [SUM3_W-1:0] y_o
);

  assign y_o = a_i + b_i;

endmodule

// File: rtl/tree_adder_scheduler.sv
// Two-requester arbiter feeding a three-step tree sum
// (a+b, c+d, then both) through one shared adder.
module tree_adder_scheduler
  import tree_adder_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [NARROW_W-1:0] a0,
  input  logic [NARROW_W-1:0] b0,
  input  logic [NARROW_W-1:0] a1,
  input  logic [NARROW_W-1:0] b1,
  input  logic [WIDE_W-1:0]   c0,
  input  logic [WIDE_W-1:0]   d0,
  input  logic [WIDE_W-1:0]   c1,
  input  logic [WIDE_W-1:0]   d1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                busy,
  output logic                done,
  output logic                done_id,
  output logic [SUM1_W-1:0]   sum1,
  output logic [SUM2_W-1:0]   sum2,
  output logic [SUM3_W-1:0]   sum3
);

  state_e              state_q, state_d;
  logic [NARROW_W-1:0] op_a_q, op_a_d;
  logic [NARROW_W-1:0] op_b_q, op_b_d;
  logic [WIDE_W-1:0]   op_c_q, op_c_d;
  logic [WIDE_W-1:0]   op_d_q, op_d_d;
  logic                id_q, id_d;
  logic                last_id_q, last_id_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                done_id_q, done_id_d;
  logic [SUM1_W-1:0]   sum1_q, sum1_d;
  logic [SUM2_W-1:0]   sum2_q, sum2_d;
  logic [SUM3_W-1:0]   sum3_q, sum3_d;
  logic                gnt0_c, gnt1_c;
  logic [SUM3_W-1:0]   add_a, add_b, add_y;

  // On a tie, FAIR serves whoever was not granted last.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (req0 && req1) begin
        if (FAIR && !last_id_q) gnt1_c = 1'b1;
        else                    gnt0_c = 1'b1;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      S1: begin
        add_a = {{(SUM3_W-NARROW_W){1'b0}}, op_a_q};
        add_b = {{(SUM3_W-NARROW_W){1'b0}}, op_b_q};
      end
      S2: begin
        add_a = {{(SUM3_W-WIDE_W){1'b0}}, op_c_q};
        add_b = {{(SUM3_W-WIDE_W){1'b0}}, op_d_q};
      end
      S3: begin
        add_a = {{(SUM3_W-SUM1_W){1'b0}}, sum1_q};
        add_b = {{(SUM3_W-SUM2_W){1'b0}}, sum2_q};
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  shared_adder10 u_add (
    .a_i (add_a),
    .b_i (add_b),
    .y_o (add_y)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    op_d_d    = op_d_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    sum1_d    = sum1_q;
    sum2_d    = sum2_q;
    sum3_d    = sum3_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0_c || gnt1_c) begin
          state_d   = S1;
          op_a_d    = gnt1_c ? a1 : a0;
          op_b_d    = gnt1_c ? b1 : b0;
          op_c_d    = gnt1_c ? c1 : c0;
          op_d_d    = gnt1_c ? d1 : d0;
          id_d      = gnt1_c;
          last_id_d = gnt1_c;
        end
      end
      S1: begin
        state_d = S2;
        sum1_d  = add_y[SUM1_W-1:0];
      end
      S2: begin
        state_d = S3;
        sum2_d  = add_y[SUM2_W-1:0];
      end
      S3: begin
        state_d = DONE;
        sum3_d  = add_y;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    done_id_d = (state_d == DONE) ? id_q : done_id_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_c_q    <= '0;
      op_d_q    <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum1_q    <= '0;
      sum2_q    <= '0;
      sum3_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_c_q    <= op_c_d;
      op_d_q    <= op_d_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum1_q    <= sum1_d;
      sum2_q    <= sum2_d;
      sum3_q    <= sum3_d;
    end
  end

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum1    = sum1_q;
  assign sum2    = sum2_q;
  assign sum3    = sum3_q;

endmodule
